// File: rtl/uart_tx.sv
// UART transmitter: one DATA_WIDTH-bit payload per accepted trmt, LSB first, 1 stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | line high, waiting for trmt
// S_START  | start bit (tx=0) for BAUD_DIV cycles
// S_DATA   | payload bits, LSB first, BAUD_DIV cycles each
// S_PARITY | even-parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (tx=1); final cycle returns to idle
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  trmt,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int BDW = $clog2(BAUD_DIV);
  localparam logic [BDW-1:0] BAUD_LAST = BDW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_q, bit_d;
  logic [BDW-1:0]        baud_q, baud_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (trmt) begin
          shift_d = tx_data;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // tx resets to 1 asynchronously so an aborted frame releases the line at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard monitor decodes frames from tx, tests check timing inline.
module tb_uart_tx;
  localparam int W = 8;
  localparam int B = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int FRAME = B * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         trmt = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx, busy, tx_done;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q[$];

  uart_tx #(.DATA_WIDTH(W), .BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .trmt(trmt),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] frame_of(input logic [W-1:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // call at a negedge; trmt is sampled at the next posedge, returns one negedge later
  task automatic send(input logic [W-1:0] d, input bit accept);
    tx_data = d;
    trmt = 1'b1;
    if (accept) exp_q.push_back(frame_of(d));
    @(negedge clk);
    trmt = 1'b0;
    tx_data = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < FRAME + 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // scoreboard monitor: decodes each frame mid-bit, drops frames cut by reset
  initial begin : monitor
    logic [NB-1:0] got, exp;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        got = '0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (c % B == B / 2) got[c / B] = tx;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got %b, expected no frame", got);
        end else begin
          exp = exp_q.pop_front();
          if (!aborted && got !== exp) begin
            errors++;
            $display("FAIL frame_bits: got %b, expected %b", got, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    trmt = 1'b1;
    tx_data = 8'hAA;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: tx/busy/done=%b%b%b, expected 100", tx, busy, tx_done);
    end
    trmt = 1'b0;
    tx_data = '0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tx/busy/done=%b%b%b, expected 100", tx, busy, tx_done);
    end
  endtask

  task automatic test_basic();
    logic [NB-1:0] f;
    int bad, n;
    f = frame_of(8'hA5);
    send(8'hA5, 1'b1);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: busy=%b tx=%b, expected busy=1 tx=0", busy, tx);
    end
    bad = 0;
    n = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (tx !== f[c / B]) bad++;
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_bit_timing: %0d cycles wrong, expected 0", bad);
    end
    checks++;
    if (n != FRAME || busy !== 1'b0 || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_len: busy cycles %0d busy=%b done=%b, expected %0d 0 1", n, busy, tx_done, FRAME);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tx_done !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky: done=%b tx=%b, expected 1 1", tx_done, tx);
    end
  endtask

  task automatic test_busy_ignore();
    int n, stray;
    send(8'h3C, 1'b1);
    repeat (49) @(negedge clk);
    send(8'hFF, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: busy=%b, expected 1", busy);
    end
    count_busy(n);
    checks++;
    if (n != FRAME - 50 || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_len: remaining %0d done=%b, expected %0d 1", n, tx_done, FRAME - 50);
    end
    stray = 0;
    for (int c = 0; c < FRAME + 20; c++) begin
      if (busy !== 1'b0 || tx !== 1'b1) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL ignore_no_second: %0d active cycles, expected 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    send(8'h00, 1'b1);
    count_busy(n);
    checks++;
    if (n != FRAME || tx_done !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: len %0d done=%b tx=%b, expected %0d 1 1", n, tx_done, tx, FRAME);
    end
    send(8'hFF, 1'b1);
    checks++;
    if (busy !== 1'b1 || tx_done !== 1'b0 || tx !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b tx=%b, expected 1 0 0", busy, tx_done, tx);
    end
    count_busy(n);
    checks++;
    if (n != FRAME || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: len %0d done=%b, expected %0d 1", n, tx_done, FRAME);
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    send(8'h55, 1'b1);
    repeat (B * 4 + 7) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3: tx=%b, expected 0", tx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: tx/busy/done=%b%b%b, expected 100", tx, busy, tx_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h81, 1'b1);
    count_busy(n);
    checks++;
    if (n != FRAME || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_refresh: len %0d done=%b, expected %0d 1", n, tx_done, FRAME);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [W-1:0] d, input logic par);
    int n;
    send(d, 1'b1);
    repeat (B * (W + 1) + B / 2 - 1) @(negedge clk);
    checks++;
    if (tx !== par) begin
      errors++;
      $display("FAIL parity_bit: data %h tx=%b, expected %b", d, tx, par);
    end
    count_busy(n);
    n = n + B * (W + 1) + B / 2 - 1;
    checks++;
    if (n != 176) begin
      errors++;
      $display("FAIL parity_len: %0d cycles, expected 176", n);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_back_to_back();
    @(negedge clk);
    test_midframe_reset();
    @(negedge clk);
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serializes one parallel byte per request into an asynchronous 8-N-1 frame on `tx`, with a configurable clocks-per-bit divider. It is the transmit counterpart of the serial sample stream that drives the receive path. In loopback benches it feeds the UART receiver directly, and in the full design it produces the response stream.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `BAUD_DIV`, default 16: clock cycles per serial bit. Must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `tx_data` in DATA_WIDTH: byte to send; sampled only on an accepted `trmt`.
- `trmt` in 1: transmit request; single-cycle strobe.
- `tx` out 1: serial line; idles high.
- `busy` out 1: frame in progress.
- `tx_done` out 1: sticky frame-complete flag.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `tx_done`=0, state IDLE, bit counter 0, baud counter 0. Reset asserted mid-frame aborts the frame and drives `tx` high immediately, without waiting for a clock.
- **States:** IDLE → START → DATA → (PARITY) → STOP → IDLE.
- **Accept:** `trmt` sampled high while `busy`=0. On acceptance:
  - `tx_data` is latched into the shift register.
  - `tx_done` clears.
  - State moves to START.
- **Ignore:** `trmt` while `busy`=1 is ignored. The latched byte is unaffected.
- **Baud counter:** counts 0..BAUD_DIV-1 in every non-IDLE state. Each bit ends when the count reaches BAUD_DIV-1, and the counter then returns to 0.
- **START:** `tx`=0 for BAUD_DIV cycles.
- **DATA:** DATA_WIDTH bits, LSB first, each held BAUD_DIV cycles. The shift register shifts right at each bit end. The bit counter counts 0..DATA_WIDTH-1.
- **STOP:** `tx`=1 for BAUD_DIV cycles. At its final cycle:
  - state → IDLE
  - `busy` → 0
  - `tx_done` → 1
- **`tx_done` lifetime:** holds until the next accepted `trmt` or reset.
- **Back-to-back:** `trmt` in the first cycle with `busy`=0 starts the next frame with no idle gap beyond that one cycle.
- **Glitch-free output:** `tx` is driven from a flop.

## Timing
- All outputs are registered.
- `trmt` sampled at edge N gives:
  - `busy`=1 and `tx`=0 from edge N onward.
  - Data bit i on `tx` over edges N+BAUD_DIV·(1+i) … N+BAUD_DIV·(2+i)−1.
  - Stop bit from edge N+BAUD_DIV·(1+DATA_WIDTH).
  - `busy` falls and `tx_done` rises at edge N+BAUD_DIV·(2+DATA_WIDTH).
- Frame length is BAUD_DIV·(DATA_WIDTH+2) cycles, plus BAUD_DIV when parity is enabled.
- Maximum throughput is one frame per frame-length + 1 cycles.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - It transmits the even-parity bit (XOR of the latched byte) for BAUD_DIV cycles.
  - Frame length becomes BAUD_DIV·(DATA_WIDTH+3).
- Undefined: no PARITY state or parity logic; 8-N-1 framing only.

## Test plan
- **Reset:** hold `rst_n`=0 with `trmt`=1. Expect `tx`=1, `busy`=0, `tx_done`=0, and the request ignored. Release reset: still idle.
- **Basic frame:** BAUD_DIV=16, send 0xA5. Expect `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles long. `busy` stays high for 160 cycles, then `tx_done`=1.
- **Busy ignore:** while sending 0x3C, pulse `trmt` with 0xFF at cycle 50. The frame still carries 0x3C and no second frame follows.
- **Back-to-back:** on the `tx_done` rising cycle's successor, send 0x00 then 0xFF. Expect:
  - a one-cycle idle gap between frames
  - `tx_done` clears on acceptance
  - the second frame's data bits are all 1
- **Mid-frame reset:** assert `rst_n`=0 at data bit 3 of 0x55. `tx` goes high asynchronously and `busy`/`tx_done` = 0. A fresh `trmt` with 0x81 then produces a correct full frame.
- **Parity (macro defined):** send 0x07. Expect parity bit 1 before stop and a frame length of 176 cycles. Send 0x03: parity bit 0.
